// File: rtl/wb_arbiter.sv
// wb_arbiter: shares the single scalar register-file write port between the ALU and
// the scalar load/store unit. Each source pushes (reg, value) results into its own
// DEPTH-entry FIFO; a per-cycle arbiter pops one head into a registered writeback bundle.
//
// Ports:
//   CLK, nRST                  clock, asynchronous active-low reset
//   flush                      synchronous drop of all buffered results (highest priority)
//   alu_wb_valid/reg/data      ALU result push; alu_wb_ready = ALU FIFO not full
//   ld_wb_valid/reg/data       load result push; ld_wb_ready = load FIFO not full
//   wb_valid/reg/data          registered register-file write bundle
//   wb_src                     0 = ALU, 1 = load (debug/scoreboard)
//
// Build option: define WB_AGE_FAIR_EN to add an ALU starvation counter; when the ALU head
// has lost STARVE_LIMIT consecutive cycles it wins the next one. Without the macro the
// load source always has fixed priority.
module wb_arbiter #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned REG_W        = 5,
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              flush,
  input  logic              alu_wb_valid,
  input  logic [REG_W-1:0]  alu_wb_reg,
  input  logic [DATA_W-1:0] alu_wb_data,
  output logic              alu_wb_ready,
  input  logic              ld_wb_valid,
  input  logic [REG_W-1:0]  ld_wb_reg,
  input  logic [DATA_W-1:0] ld_wb_data,
  output logic              ld_wb_ready,
  output logic              wb_valid,
  output logic [REG_W-1:0]  wb_reg,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_src
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam bit SrcAlu = 1'b0;
  localparam bit SrcLd  = 1'b1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("wb_arbiter: DEPTH must be a power of two >= 2");
  end
  if (STARVE_LIMIT == 0) begin : g_bad_starve
    $error("wb_arbiter: STARVE_LIMIT must be >= 1");
  end

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  // Per-source state, indexed by SrcAlu / SrcLd.
  logic [1:0]      in_valid;
  entry_t          in_entry [2];
  logic [1:0]      head;
  logic [1:0]      ready;
  logic [1:0]      push;
  logic [1:0]      grant;
  logic [1:0]      pop;
  entry_t          mem_q    [2][DEPTH];
  logic [PtrW-1:0] wptr_q   [2];
  logic [PtrW-1:0] rptr_q   [2];
  logic [CntW-1:0] cnt_q    [2];

  logic              wb_valid_q;
  logic [REG_W-1:0]  wb_reg_q;
  logic [DATA_W-1:0] wb_data_q;
  logic              wb_src_q;

  assign in_valid        = {ld_wb_valid, alu_wb_valid};
  assign in_entry[SrcAlu] = {alu_wb_reg, alu_wb_data};
  assign in_entry[SrcLd]  = {ld_wb_reg, ld_wb_data};

  // Ready depends only on occupancy (gated low while in reset). Register-0 entries and
  // entries offered during flush complete the handshake but are never stored.
  always_comb begin
    head  = '0;
    ready = '0;
    push  = '0;
    pop   = '0;
    for (int s = 0; s < 2; s++) begin
      head[s]  = (cnt_q[s] != '0);
      ready[s] = (cnt_q[s] != CntW'(DEPTH)) & nRST;
      push[s]  = in_valid[s] & ready[s] & (in_entry[s].rd != '0) & ~flush;
      pop[s]   = grant[s] & ~flush;
    end
  end

  assign alu_wb_ready = ready[SrcAlu];
  assign ld_wb_ready  = ready[SrcLd];

`ifdef WB_AGE_FAIR_EN
  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

  logic [StarveW-1:0] starve_q, starve_d;
  logic               alu_force;

  assign alu_force = head[SrcAlu] && (starve_q == StarveW'(STARVE_LIMIT));

  always_comb begin
    grant    = '0;
    starve_d = starve_q;
    if (head[SrcAlu] && (alu_force || !head[SrcLd])) begin
      grant[SrcAlu] = 1'b1;
    end else if (head[SrcLd]) begin
      grant[SrcLd] = 1'b1;
    end
    // Counts consecutive losses of a present ALU head; clears on win, empty or flush.
    if (flush || !head[SrcAlu] || grant[SrcAlu]) begin
      starve_d = '0;
    end else begin
      starve_d = starve_q + StarveW'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  // Load data cannot be re-fetched cheaply, so load always wins a tie.
  always_comb begin
    grant = '0;
    if (head[SrcLd]) begin
      grant[SrcLd] = 1'b1;
    end else if (head[SrcAlu]) begin
      grant[SrcAlu] = 1'b1;
    end
  end
`endif

  // FIFO pointers and occupancy.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int s = 0; s < 2; s++) begin
        wptr_q[s] <= '0;
        rptr_q[s] <= '0;
        cnt_q[s]  <= '0;
      end
    end else if (flush) begin
      for (int s = 0; s < 2; s++) begin
        wptr_q[s] <= '0;
        rptr_q[s] <= '0;
        cnt_q[s]  <= '0;
      end
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (push[s]) wptr_q[s] <= wptr_q[s] + PtrW'(1);
        if (pop[s])  rptr_q[s] <= rptr_q[s] + PtrW'(1);
        cnt_q[s] <= cnt_q[s] + CntW'(push[s]) - CntW'(pop[s]);
      end
    end
  end

  // Storage needs no reset: occupancy alone says which slots are live.
  always_ff @(posedge CLK) begin
    for (int s = 0; s < 2; s++) begin
      if (push[s]) mem_q[s][wptr_q[s]] <= in_entry[s];
    end
  end

  // Registered writeback bundle; reg/data/src hold when nothing is written.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wb_valid_q <= 1'b0;
      wb_reg_q   <= '0;
      wb_data_q  <= '0;
      wb_src_q   <= 1'b0;
    end else begin
      wb_valid_q <= |pop;
      if (|pop) begin
        wb_src_q <= pop[SrcLd];
        if (pop[SrcLd]) begin
          {wb_reg_q, wb_data_q} <= mem_q[SrcLd][rptr_q[SrcLd]];
        end else begin
          {wb_reg_q, wb_data_q} <= mem_q[SrcAlu][rptr_q[SrcAlu]];
        end
      end
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_reg   = wb_reg_q;
  assign wb_data  = wb_data_q;
  assign wb_src   = wb_src_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios followed by random traffic,
// all checked cycle by cycle against a queue-based reference model.
module tb_wb_arbiter;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned REG_W        = 5;
  localparam int unsigned DEPTH        = 2;
  localparam int unsigned STARVE_LIMIT = 4;

  logic              CLK = 1'b0;
  logic              nRST = 1'b1;
  logic              flush = 1'b0;
  logic              alu_wb_valid = 1'b0;
  logic [REG_W-1:0]  alu_wb_reg = '0;
  logic [DATA_W-1:0] alu_wb_data = '0;
  logic              alu_wb_ready;
  logic              ld_wb_valid = 1'b0;
  logic [REG_W-1:0]  ld_wb_reg = '0;
  logic [DATA_W-1:0] ld_wb_data = '0;
  logic              ld_wb_ready;
  logic              wb_valid;
  logic [REG_W-1:0]  wb_reg;
  logic [DATA_W-1:0] wb_data;
  logic              wb_src;

  always #5 CLK = ~CLK;

  wb_arbiter #(
    .DATA_W      (DATA_W),
    .REG_W       (REG_W),
    .DEPTH       (DEPTH),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .flush       (flush),
    .alu_wb_valid(alu_wb_valid),
    .alu_wb_reg  (alu_wb_reg),
    .alu_wb_data (alu_wb_data),
    .alu_wb_ready(alu_wb_ready),
    .ld_wb_valid (ld_wb_valid),
    .ld_wb_reg   (ld_wb_reg),
    .ld_wb_data  (ld_wb_data),
    .ld_wb_ready (ld_wb_ready),
    .wb_valid    (wb_valid),
    .wb_reg      (wb_reg),
    .wb_data     (wb_data),
    .wb_src      (wb_src)
  );

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } ent_t;

  // Pending entries at each source (held until accepted) and model FIFO contents.
  ent_t alu_src[$];
  ent_t ld_src[$];
  ent_t alu_m[$];
  ent_t ld_m[$];
  int   alu_wait = 0;

  logic              exp_valid = 1'b0;
  logic [REG_W-1:0]  exp_reg = '0;
  logic [DATA_W-1:0] exp_data = '0;
  logic              exp_src = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  function automatic ent_t mk(input int unsigned rd, input logic [DATA_W-1:0] data);
    ent_t e;
    e.rd   = REG_W'(rd);
    e.data = data;
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    alu_wb_valid = (alu_src.size() > 0);
    if (alu_wb_valid) {alu_wb_reg, alu_wb_data} = alu_src[0];
    else {alu_wb_reg, alu_wb_data} = {REG_W'($urandom), DATA_W'($urandom)};
    ld_wb_valid = (ld_src.size() > 0);
    if (ld_wb_valid) {ld_wb_reg, ld_wb_data} = ld_src[0];
    else {ld_wb_reg, ld_wb_data} = {REG_W'($urandom), DATA_W'($urandom)};
  endtask

  // One clock: drive at the negedge, check readies, advance the model, check outputs
  // #1 after the posedge, return at the next negedge.
  task automatic cycle(input logic do_flush);
    bit   acc_a, acc_l, ga, gl;
    ent_t e;
    flush = do_flush;
    drive();
    #1;
    check("alu_ready", 64'(alu_wb_ready), 64'(alu_m.size() < DEPTH));
    check("ld_ready", 64'(ld_wb_ready), 64'(ld_m.size() < DEPTH));
    acc_a = alu_wb_valid && (alu_m.size() < DEPTH);
    acc_l = ld_wb_valid && (ld_m.size() < DEPTH);
    if (do_flush) begin
      alu_m.delete();
      ld_m.delete();
      alu_wait  = 0;
      exp_valid = 1'b0;
    end else begin
      ga = 0;
      gl = 0;
      if (ld_m.size() > 0 && alu_m.size() > 0) begin
`ifdef WB_AGE_FAIR_EN
        if (alu_wait == int'(STARVE_LIMIT)) ga = 1; else gl = 1;
`else
        gl = 1;
`endif
      end else if (ld_m.size() > 0) begin
        gl = 1;
      end else if (alu_m.size() > 0) begin
        ga = 1;
      end
      if (alu_m.size() > 0 && !ga) alu_wait++; else alu_wait = 0;
      exp_valid = ga | gl;
      if (gl) begin
        e = ld_m.pop_front();
        exp_reg  = e.rd;
        exp_data = e.data;
        exp_src  = 1'b1;
      end
      if (ga) begin
        e = alu_m.pop_front();
        exp_reg  = e.rd;
        exp_data = e.data;
        exp_src  = 1'b0;
      end
      if (acc_a && alu_src[0].rd != '0) alu_m.push_back(alu_src[0]);
      if (acc_l && ld_src[0].rd != '0) ld_m.push_back(ld_src[0]);
    end
    if (acc_a) void'(alu_src.pop_front());
    if (acc_l) void'(ld_src.pop_front());
    @(posedge CLK);
    #1;
    check("wb_valid", 64'(wb_valid), 64'(exp_valid));
    check("wb_reg", 64'(wb_reg), 64'(exp_reg));
    check("wb_data", 64'(wb_data), 64'(exp_data));
    check("wb_src", 64'(wb_src), 64'(exp_src));
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wb_valid"}, 64'(wb_valid), 64'd0);
    check({tag, "_wb_reg"}, 64'(wb_reg), 64'd0);
    check({tag, "_wb_data"}, 64'(wb_data), 64'd0);
    check({tag, "_wb_src"}, 64'(wb_src), 64'd0);
    check({tag, "_alu_ready"}, 64'(alu_wb_ready), 64'd0);
    check({tag, "_ld_ready"}, 64'(ld_wb_ready), 64'd0);
  endtask

  initial begin
    // Power-on reset
    #1 nRST = 1'b0;
    #2;
    check_all_zero("reset");
    @(negedge CLK);
    nRST = 1'b1;
    idle(2);

    // Single ALU push on an idle arbiter
    alu_src.push_back(mk(3, 32'hDEADBEEF));
    idle(4);

    // Simultaneous ALU and load push: load first, then ALU
    alu_src.push_back(mk(4, 32'h11));
    ld_src.push_back(mk(5, 32'h22));
    idle(4);

    // Three ALU entries while load saturates the port
    for (int i = 0; i < 12; i++) ld_src.push_back(mk(i % 31 + 1, 32'h100 + i));
    alu_src.push_back(mk(10, 32'hA));
    alu_src.push_back(mk(11, 32'hB));
    alu_src.push_back(mk(12, 32'hC));
    idle(20);

    // Load stream with one pending ALU entry (starvation behaviour)
    for (int i = 0; i < 10; i++) ld_src.push_back(mk(20 + i, 32'h200 + i));
    alu_src.push_back(mk(7, 32'h777));
    idle(16);

    // Register-0 pushes from both sources
    alu_src.push_back(mk(0, 32'h0BAD));
    ld_src.push_back(mk(0, 32'h0BAD));
    idle(4);

    // Fill, then flush for one cycle
    for (int i = 0; i < 3; i++) begin
      alu_src.push_back(mk(13 + i, 32'h300 + i));
      ld_src.push_back(mk(16 + i, 32'h400 + i));
    end
    idle(2);
    cycle(1'b1);
    idle(4);
    cycle(1'b1);
    idle(1);

    // Asynchronous reset mid-drain
    for (int i = 0; i < 3; i++) begin
      alu_src.push_back(mk(1 + i, 32'h500 + i));
      ld_src.push_back(mk(4 + i, 32'h600 + i));
    end
    idle(2);
    #2 nRST = 1'b0;
    #1;
    check_all_zero("async_rst");
    alu_src.delete();
    ld_src.delete();
    alu_m.delete();
    ld_m.delete();
    alu_wait  = 0;
    exp_valid = 1'b0;
    exp_reg   = '0;
    exp_data  = '0;
    exp_src   = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    idle(3);

    // Random traffic with occasional reg-0 entries and flushes
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0 && alu_src.size() < 3)
        alu_src.push_back(mk($urandom_range(0, 31), DATA_W'($urandom)));
      if ($urandom_range(0, 1) == 0 && ld_src.size() < 3)
        ld_src.push_back(mk($urandom_range(0, 31), DATA_W'($urandom)));
      cycle($urandom_range(0, 39) == 0);
    end
    idle(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
